// File: rtl/sdram_reader_pkg.sv
// Shared types and constants for the SDRAM burst frame reader.
package sdram_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    // 1920x1080 at 32 bpp packed into 64-bit words.
    localparam int unsigned FRAME_WORDS_1080P = 32'h000F_D200;
    localparam int unsigned DEFAULT_BUF0_BASE = 32'h0400_0000;

    function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/sdram_burst_reader_credit.sv
// In-flight beat counter and downstream FIFO credit check for the burst reader.
module read_credit_tracker
    import sdram_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter int unsigned FIFO_MARGIN = 4,
    parameter int unsigned BCNT_W      = burst_cnt_w(16),
    parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  logic [BCNT_W-1:0] accept_len_i,
    input  logic [BCNT_W-1:0] req_len_i,
    input  logic              beat_i,
    input  logic [CNT_W-1:0]  wrusedw_i,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              credit_ok_o,
    output logic              stray_o
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned LIMIT = FIFO_DEPTH - FIFO_MARGIN;

    logic [CNT_W-1:0] out_q, out_d;
    logic [SUM_W-1:0] need;
    logic             live_beat;

    // A beat with nothing outstanding belongs to no burst we issued.
    assign live_beat = beat_i && (out_q != '0);
    assign stray_o   = beat_i && (out_q == '0);

    always_comb begin
        out_d = out_q;
        if (accept_i) begin
            out_d = out_d + CNT_W'(accept_len_i);
        end
        if (live_beat) begin
            out_d = out_d - CNT_W'(1);
        end
        need = SUM_W'(wrusedw_i) + SUM_W'(out_q) + SUM_W'(req_len_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign outstanding_o = out_q;
    assign credit_ok_o   = (need <= SUM_W'(LIMIT));

endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master streaming frames from an SDRAM buffer into a pixel FIFO.
module sdram_burst_reader
    import sdram_reader_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter int unsigned FIFO_MARGIN = 4,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_1080P,
    parameter int unsigned NUM_BUFS    = 2,
    parameter int unsigned BUF0_BASE   = DEFAULT_BUF0_BASE,
    parameter int unsigned BUF_STRIDE  = 32'h0010_0000
) (
    input  logic                                              sdram_clk,
    input  logic                                              rst_n,
    input  logic                                              enable_i,
    input  logic                                              loop_i,
    input  logic                                              frame_ready_i,
    input  logic [((NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1)-1:0] buf_sel_i,
    output logic                                              frame_start_o,
    output logic                                              frame_done_o,
    output logic                                              busy_o,
    output logic [ADDR_W-1:0]                                 sdram_address_o,
    output logic [$clog2(MAX_BURST):0]                        sdram_burstcount_o,
    output logic                                              sdram_read_o,
    input  logic                                              sdram_waitrequest_i,
    input  logic [DATA_W-1:0]                                 sdram_readdata_i,
    input  logic                                              sdram_readdatavalid_i,
    output logic                                              fifo_wrreq_o,
    output logic [DATA_W-1:0]                                 fifo_data_o,
    input  logic [$clog2(FIFO_DEPTH):0]                       fifo_wrusedw_i,
    input  logic                                              fifo_full_i,
    output logic                                              err_o
);

    localparam int unsigned BCNT_W = burst_cnt_w(MAX_BURST);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned REM_W  = $clog2(FRAME_WORDS + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic [BCNT_W-1:0] cmd_len_q, cmd_len_d, blen;
    logic              read_q, read_d;
    logic              abort_q, abort_d;
    logic              start_q, start_d;
    logic              wrreq_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              accept, credit_ok, stray;
    logic [CNT_W-1:0]  outstanding;

    assign accept = read_q && !sdram_waitrequest_i;
    assign blen   = (32'(remaining_q) < MAX_BURST) ? BCNT_W'(remaining_q) : BCNT_W'(MAX_BURST);

    read_credit_tracker #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FIFO_MARGIN (FIFO_MARGIN),
        .BCNT_W      (BCNT_W),
        .CNT_W       (CNT_W)
    ) u_credit (
        .clk_i         (sdram_clk),
        .rst_ni        (rst_n),
        .accept_i      (accept),
        .accept_len_i  (cmd_len_q),
        .req_len_i     (blen),
        .beat_i        (sdram_readdatavalid_i),
        .wrusedw_i     (fifo_wrusedw_i),
        .outstanding_o (outstanding),
        .credit_ok_o   (credit_ok),
        .stray_o       (stray)
    );

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        remaining_d = remaining_q;
        read_d      = read_q;
        abort_d     = abort_q;
        start_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && frame_ready_i) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                next_addr_d = ADDR_W'(BUF0_BASE) + ADDR_W'(buf_sel_i) * ADDR_W'(BUF_STRIDE);
                remaining_d = REM_W'(FRAME_WORDS);
                abort_d     = 1'b0;
                start_d     = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                // A posted command must stay until accepted, even if enable drops.
                if (read_q) begin
                    if (!sdram_waitrequest_i) begin
                        read_d      = 1'b0;
                        next_addr_d = next_addr_q + ADDR_W'(cmd_len_q);
                        remaining_d = remaining_q - REM_W'(cmd_len_q);
                        if (remaining_q == REM_W'(cmd_len_q)) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (!enable_i) begin
                    abort_d = 1'b1;
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    read_d     = 1'b1;
                    cmd_addr_d = next_addr_q;
                    cmd_len_d  = blen;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_d = abort_q ? IDLE : DONE;
                end
            end
            DONE: begin
                state_d = (loop_i && enable_i && frame_ready_i) ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_addr_q <= ADDR_W'(BUF0_BASE);
            cmd_addr_q  <= ADDR_W'(BUF0_BASE);
            cmd_len_q   <= '0;
            remaining_q <= '0;
            read_q      <= 1'b0;
            abort_q     <= 1'b0;
            start_q     <= 1'b0;
            wrreq_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            remaining_q <= remaining_d;
            read_q      <= read_d;
            abort_q     <= abort_d;
            start_q     <= start_d;
            wrreq_q     <= sdram_readdatavalid_i && !stray;
            if (sdram_readdatavalid_i && !stray) begin
                data_q <= sdram_readdata_i;
            end
            err_q <= err_q || stray || (wrreq_q && fifo_full_i);
        end
    end

    // Start is registered out of ARM, done is decoded from DONE: back-to-back
    // looped frames therefore show start two cycles after done.
    assign frame_start_o      = start_q;
    assign frame_done_o       = (state_q == DONE) && !abort_q;
    assign busy_o             = (state_q != IDLE);
    assign sdram_address_o    = cmd_addr_q;
    assign sdram_burstcount_o = cmd_len_q;
    assign sdram_read_o       = read_q;
    assign fifo_wrreq_o       = wrreq_q;
    assign fifo_data_o        = data_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader with a zero-latency Avalon slave model.
module tb_sdram_burst_reader;

    localparam logic [26:0] BASE0  = 27'h400_0000;
    localparam logic [26:0] STRIDE = 27'h100;

    logic        sdram_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        loop_i = 1'b0;
    logic        frame_ready_i = 1'b0;
    logic [0:0]  buf_sel_i = 1'b0;
    logic        frame_start_o, frame_done_o, busy_o;
    logic [26:0] sdram_address_o;
    logic [4:0]  sdram_burstcount_o;
    logic        sdram_read_o;
    logic        sdram_waitrequest_i = 1'b0;
    logic [63:0] sdram_readdata_i = '0;
    logic        sdram_readdatavalid_i = 1'b0;
    logic        fifo_wrreq_o;
    logic [63:0] fifo_data_o;
    logic [6:0]  fifo_wrusedw_i = '0;
    logic        fifo_full_i = 1'b0;
    logic        err_o;

    sdram_burst_reader #(
        .DATA_W      (64),
        .ADDR_W      (27),
        .MAX_BURST   (16),
        .FIFO_DEPTH  (64),
        .FIFO_MARGIN (4),
        .FRAME_WORDS (40),
        .NUM_BUFS    (2),
        .BUF0_BASE   (32'h0400_0000),
        .BUF_STRIDE  (32'h100)
    ) dut (
        .sdram_clk             (sdram_clk),
        .rst_n                 (rst_n),
        .enable_i              (enable_i),
        .loop_i                (loop_i),
        .frame_ready_i         (frame_ready_i),
        .buf_sel_i             (buf_sel_i),
        .frame_start_o         (frame_start_o),
        .frame_done_o          (frame_done_o),
        .busy_o                (busy_o),
        .sdram_address_o       (sdram_address_o),
        .sdram_burstcount_o    (sdram_burstcount_o),
        .sdram_read_o          (sdram_read_o),
        .sdram_waitrequest_i   (sdram_waitrequest_i),
        .sdram_readdata_i      (sdram_readdata_i),
        .sdram_readdatavalid_i (sdram_readdatavalid_i),
        .fifo_wrreq_o          (fifo_wrreq_o),
        .fifo_data_o           (fifo_data_o),
        .fifo_wrusedw_i        (fifo_wrusedw_i),
        .fifo_full_i           (fifo_full_i),
        .err_o                 (err_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    int cyc = 0;
    always @(posedge sdram_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [26:0] beat_q[$];
    logic [26:0] cmd_addr[$];
    int          cmd_len[$];
    logic [63:0] wr_data[$];
    int          start_cnt = 0, done_cnt = 0;
    int          last_start_cyc = 0, last_done_cyc = 0;
    int          stall_cmd = -1, stall_left = 0, stall_seen = 0, unstable = 0;
    bit          hold_beats = 1'b0;
    logic [26:0] held_addr = '0;
    logic [4:0]  held_len = '0;

    function automatic logic [63:0] mkdata(input logic [26:0] a);
        return {32'hDA7A_0000, 5'd0, a};
    endfunction

    // Slave and FIFO monitor: decisions made at negedge take effect at the next posedge.
    always @(negedge sdram_clk) begin
        if (fifo_wrreq_o) wr_data.push_back(fifo_data_o);
        if (frame_start_o) begin start_cnt++; last_start_cyc = cyc; end
        if (frame_done_o) begin done_cnt++; last_done_cyc = cyc; end
        if (beat_q.size() > 0 && !hold_beats) begin
            sdram_readdatavalid_i = 1'b1;
            sdram_readdata_i      = mkdata(beat_q.pop_front());
        end else begin
            sdram_readdatavalid_i = 1'b0;
        end
        sdram_waitrequest_i = 1'b0;
        if (sdram_read_o) begin
            if (cmd_addr.size() == stall_cmd && stall_seen > 0 &&
                (sdram_address_o != held_addr || sdram_burstcount_o != held_len)) unstable++;
            if (cmd_addr.size() == stall_cmd && stall_left > 0) begin
                held_addr = sdram_address_o;
                held_len  = sdram_burstcount_o;
                stall_left--;
                stall_seen++;
                sdram_waitrequest_i = 1'b1;
            end else begin
                cmd_addr.push_back(sdram_address_o);
                cmd_len.push_back(int'(sdram_burstcount_o));
                for (int i = 0; i < int'(sdram_burstcount_o); i++)
                    beat_q.push_back(sdram_address_o + 27'(i));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic do_reset();
        enable_i = 1'b0; frame_ready_i = 1'b0; loop_i = 1'b0; buf_sel_i = 1'b0;
        fifo_wrusedw_i = '0; hold_beats = 1'b0; stall_cmd = -1; stall_left = 0;
        rst_n = 1'b0;
        tick(); tick();
        beat_q.delete(); cmd_addr.delete(); cmd_len.delete(); wr_data.delete();
        start_cnt = 0; done_cnt = 0; stall_seen = 0; unstable = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame(input logic sel);
        buf_sel_i = sel; enable_i = 1'b1; frame_ready_i = 1'b1;
        for (int k = 0; k < 20 && start_cnt == 0; k++) tick();
        frame_ready_i = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 400 && done_cnt < n; k++) tick();
        tick(); tick(); tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy_o), 64'(0));
        check({tag, "_read"},  64'(sdram_read_o), 64'(0));
        check({tag, "_bcnt"},  64'(sdram_burstcount_o), 64'(0));
        check({tag, "_addr"},  64'(sdram_address_o), 64'(BASE0));
        check({tag, "_wrreq"}, 64'(fifo_wrreq_o), 64'(0));
        check({tag, "_data"},  fifo_data_o, 64'(0));
        check({tag, "_start"}, 64'(frame_start_o), 64'(0));
        check({tag, "_done"},  64'(frame_done_o), 64'(0));
        check({tag, "_err"},   64'(err_o), 64'(0));
    endtask

    typedef struct {
        logic        sel;
        logic [6:0]  used;
        bit          exp_issue;
        logic [26:0] exp_addr;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int wr_n;

        // First-burst credit threshold: used + 0 + 16 must not exceed 60.
        vecs[0] = '{sel: 1'b0, used: 7'd0,  exp_issue: 1'b1, exp_addr: BASE0,          exp_len: 16};
        vecs[1] = '{sel: 1'b1, used: 7'd44, exp_issue: 1'b1, exp_addr: BASE0 + STRIDE, exp_len: 16};
        vecs[2] = '{sel: 1'b0, used: 7'd45, exp_issue: 1'b0, exp_addr: BASE0,          exp_len: 16};
        vecs[3] = '{sel: 1'b1, used: 7'd64, exp_issue: 1'b0, exp_addr: BASE0 + STRIDE, exp_len: 16};
        vecs[4] = '{sel: 1'b1, used: 7'd20, exp_issue: 1'b1, exp_addr: BASE0 + STRIDE, exp_len: 16};

        tick(); tick();
        check_reset_outputs("rst");

        // Basic frame: bursts 16,16,8 then one done.
        do_reset();
        start_frame(1'b0);
        wait_done(1);
        check("basic_ncmd", 64'(cmd_addr.size()), 64'(3));
        if (cmd_addr.size() == 3) begin
            check("basic_a0", 64'(cmd_addr[0]), 64'(BASE0));
            check("basic_a1", 64'(cmd_addr[1]), 64'(BASE0 + 27'h10));
            check("basic_a2", 64'(cmd_addr[2]), 64'(BASE0 + 27'h20));
            check("basic_l0", 64'(cmd_len[0]), 64'(16));
            check("basic_l1", 64'(cmd_len[1]), 64'(16));
            check("basic_l2", 64'(cmd_len[2]), 64'(8));
        end
        check("basic_nwr", 64'(wr_data.size()), 64'(40));
        for (int i = 0; i < 40 && i < wr_data.size(); i++)
            check($sformatf("basic_d%0d", i), wr_data[i], mkdata(BASE0 + 27'(i)));
        check("basic_done", 64'(done_cnt), 64'(1));
        check("basic_start", 64'(start_cnt), 64'(1));
        check("basic_err", 64'(err_o), 64'(0));
        check("basic_busy", 64'(busy_o), 64'(0));

        // Buffer 1, selection changed mid-frame.
        do_reset();
        start_frame(1'b1);
        buf_sel_i = 1'b0;
        wait_done(1);
        check("sel_ncmd", 64'(cmd_addr.size()), 64'(3));
        if (cmd_addr.size() == 3) begin
            check("sel_a0", 64'(cmd_addr[0]), 64'(BASE0 + STRIDE));
            check("sel_a2", 64'(cmd_addr[2]), 64'(BASE0 + STRIDE + 27'h20));
        end
        check("sel_nwr", 64'(wr_data.size()), 64'(40));
        if (wr_data.size() == 40)
            check("sel_dlast", wr_data[39], mkdata(BASE0 + STRIDE + 27'd39));

        // Five-cycle waitrequest on the second command.
        do_reset();
        stall_cmd = 1; stall_left = 5;
        start_frame(1'b0);
        wait_done(1);
        check("stall_ncmd", 64'(cmd_addr.size()), 64'(3));
        check("stall_cycles", 64'(stall_seen), 64'(5));
        check("stall_unstable", 64'(unstable), 64'(0));
        check("stall_nwr", 64'(wr_data.size()), 64'(40));
        if (cmd_addr.size() == 3)
            check("stall_a1", 64'(cmd_addr[1]), 64'(BASE0 + 27'h10));

        // Credit: level 40 permits first burst, blocks second until level <= 28.
        do_reset();
        fifo_wrusedw_i = 7'd40; hold_beats = 1'b1;
        start_frame(1'b0);
        for (int k = 0; k < 30; k++) tick();
        check("credit_first", 64'(cmd_addr.size()), 64'(1));
        fifo_wrusedw_i = 7'd29;
        for (int k = 0; k < 10; k++) tick();
        check("credit_29", 64'(cmd_addr.size()), 64'(1));
        fifo_wrusedw_i = 7'd28;
        for (int k = 0; k < 10 && cmd_addr.size() < 2; k++) tick();
        check("credit_28", 64'(cmd_addr.size()), 64'(2));
        hold_beats = 1'b0; fifo_wrusedw_i = '0;
        wait_done(1);
        check("credit_nwr", 64'(wr_data.size()), 64'(40));
        check("credit_done", 64'(done_cnt), 64'(1));

        // Enable dropped right after the first accept.
        do_reset();
        start_frame(1'b0);
        for (int k = 0; k < 20 && cmd_addr.size() == 0; k++) tick();
        enable_i = 1'b0;
        for (int k = 0; k < 100 && (busy_o || wr_data.size() < 16); k++) tick();
        tick(); tick();
        check("abort_ncmd", 64'(cmd_addr.size()), 64'(1));
        check("abort_nwr", 64'(wr_data.size()), 64'(16));
        check("abort_busy", 64'(busy_o), 64'(0));
        check("abort_done", 64'(done_cnt), 64'(0));
        check("abort_err", 64'(err_o), 64'(0));

        // Looping with frame_ready held.
        do_reset();
        loop_i = 1'b1; enable_i = 1'b1; frame_ready_i = 1'b1;
        for (int k = 0; k < 400 && done_cnt < 1; k++) tick();
        for (int k = 0; k < 10 && start_cnt < 2; k++) tick();
        check("loop_start2", 64'(start_cnt), 64'(2));
        check("loop_gap", 64'(last_start_cyc - last_done_cyc), 64'(2));
        loop_i = 1'b0; frame_ready_i = 1'b0;
        wait_done(2);
        check("loop_ncmd", 64'(cmd_addr.size()), 64'(6));
        if (cmd_addr.size() == 6) begin
            check("loop_a3", 64'(cmd_addr[3]), 64'(BASE0));
            check("loop_a5", 64'(cmd_addr[5]), 64'(BASE0 + 27'h20));
        end
        check("loop_nwr", 64'(wr_data.size()), 64'(80));
        if (wr_data.size() == 80)
            check("loop_d40", wr_data[40], mkdata(BASE0));
        check("loop_busy", 64'(busy_o), 64'(0));

        // Reset pulse mid-burst: late beats are stray.
        do_reset();
        start_frame(1'b0);
        for (int k = 0; k < 50 && wr_data.size() < 4; k++) tick();
        enable_i = 1'b0; rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        wr_n = wr_data.size();
        for (int k = 0; k < 40; k++) tick();
        check("midrst_nwr", 64'(wr_data.size()), 64'(wr_n));
        check("midrst_err", 64'(err_o), 64'(1));
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_qempty", 64'(beat_q.size()), 64'(0));

        // Table-driven first-burst credit and address vectors.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            fifo_wrusedw_i = vecs[i].used; hold_beats = 1'b1;
            start_frame(vecs[i].sel);
            for (int k = 0; k < 12; k++) tick();
            check($sformatf("vec%0d_start", i), 64'(start_cnt), 64'(1));
            check($sformatf("vec%0d_issue", i), 64'(cmd_addr.size() > 0), 64'(vecs[i].exp_issue));
            if (vecs[i].exp_issue && cmd_addr.size() > 0) begin
                check($sformatf("vec%0d_addr", i), 64'(cmd_addr[0]), 64'(vecs[i].exp_addr));
                check($sformatf("vec%0d_len", i), 64'(cmd_len[0]), 64'(vecs[i].exp_len));
            end
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
